// File: rtl/dm_cache_core.sv
// Direct-mapped cache core: tag/data arrays plus miss FSM, with write-through/no-allocate
// stores, whole-cache flush, backpressured line-fill memory port and saturating hit/miss counters.
module dm_cache_core #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LINE_W    = 512,
  parameter int NUM_LINES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              hit,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam int OFF_B  = $clog2(LINE_W / 8);
  localparam int WSEL_B = $clog2(LINE_W / DATA_W);
  localparam int IDX_B  = $clog2(NUM_LINES);
  localparam int TAG_B  = ADDR_W - IDX_B - OFF_B;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_FILL,
    S_WRITE_MEM,
    S_RESPOND
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0]    req_addr;
  logic                 req_we;
  logic [DATA_W-1:0]    req_wdata;
  logic [DATA_W-1:0]    rd_word;

  logic [NUM_LINES-1:0] valid;
  logic [TAG_B-1:0]     tag_mem  [NUM_LINES];
  logic [LINE_W-1:0]    data_mem [NUM_LINES];

  logic [TAG_B-1:0]     req_tag;
  logic [IDX_B-1:0]     req_idx;
  logic [WSEL_B-1:0]    req_wsel;
  logic [LINE_W-1:0]    cur_line;
  logic                 match;
  logic                 accept;
  logic                 flush_go;
  logic                 fill_done;

  assign req_tag   = req_addr[ADDR_W-1 -: TAG_B];
  assign req_idx   = req_addr[OFF_B +: IDX_B];
  assign req_wsel  = req_addr[OFF_B-1 -: WSEL_B];
  assign cur_line  = data_mem[req_idx];
  assign match     = valid[req_idx] && (tag_mem[req_idx] == req_tag);

  // Flush has priority over a simultaneous request; the request simply isn't accepted.
  assign cpu_ready = (state == S_IDLE) && !flush && rst_n;
  assign accept    = cpu_req && cpu_ready;
  assign flush_go  = flush && (state == S_IDLE);
  assign fill_done = (state == S_FILL) && mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
      state <= state_nxt;
    end
  end

  // Memory port is decoded straight from state, so an async reset drops mem_req at once.
  always_comb begin
    // NOTE: every output gets a default first; a path that skips an assignment would infer a latch.
    state_nxt = state;
    hit       = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_LOOKUP;
      end
      S_LOOKUP: begin
        hit = match;
        if (req_we)     state_nxt = S_WRITE_MEM;
        else if (match) state_nxt = S_RESPOND;
        else            state_nxt = S_FILL;
      end
      S_FILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_addr[ADDR_W-1:OFF_B], {OFF_B{1'b0}}};
        if (mem_ack) state_nxt = S_RESPOND;
      end
      S_WRITE_MEM: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = req_addr;
        mem_wdata = req_wdata;
        if (mem_ack) state_nxt = S_RESPOND;
      end
      S_RESPOND: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_addr  <= '0;
      req_we    <= 1'b0;
      req_wdata <= '0;
      rd_word   <= '0;
      cpu_rdata <= '0;
      cpu_done  <= 1'b0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      valid     <= '0;
    end else begin
      cpu_done <= (state == S_RESPOND);

      if (accept) begin
        req_addr  <= cpu_addr;
        req_we    <= cpu_we;
        req_wdata <= cpu_wdata;
      end

      if (flush_go) valid <= '0;

      if (state == S_LOOKUP) begin
        if (match) begin
          if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
          if (!req_we) rd_word <= cur_line[req_wsel*DATA_W +: DATA_W];
        end else begin
          if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
        end
      end

      if (fill_done) begin
        valid[req_idx] <= 1'b1;
        rd_word        <= mem_rdata[req_wsel*DATA_W +: DATA_W];
      end

      // cpu_rdata only changes when a read completes, so it holds across writes.
      if ((state == S_RESPOND) && !req_we) cpu_rdata <= rd_word;
    end
  end

  // NOTE: tag/data arrays are not reset; the reset valid bits make their contents don't-care.
  always_ff @(posedge clk) begin
    if ((state == S_LOOKUP) && req_we && match)
      data_mem[req_idx][req_wsel*DATA_W +: DATA_W] <= req_wdata;
    if (fill_done) begin
      data_mem[req_idx] <= mem_rdata;
      tag_mem[req_idx]  <= req_tag;
    end
  end

endmodule

// File: tb/tb_dm_cache_core.sv
// Scoreboard bench for dm_cache_core: stimulus queues expected CPU and memory transactions,
// independent monitor/memory-model processes pop and compare them when the DUT presents them.
module tb_dm_cache_core;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req, cpu_we, flush;
  logic [31:0]   cpu_addr, cpu_wdata;
  logic          cpu_ready, cpu_done, hit;
  logic [31:0]   cpu_rdata;
  logic          mem_req, mem_we, mem_ack;
  logic [31:0]   mem_addr, mem_wdata;
  logic [511:0]  mem_rdata;
  logic [31:0]   hit_cnt, miss_cnt;

  typedef struct {
    logic        we;
    logic [31:0] rdata;
  } cpu_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_exp_t;

  cpu_exp_t    cpu_q[$];
  mem_exp_t    mem_q[$];

  int          pass_cnt  = 0;
  int          total_cnt = 0;
  int          ack_delay = 0;
  int          last_req_len = 0;
  logic [31:0] fill_base = '0;

  dm_cache_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ready (cpu_ready),
    .cpu_done  (cpu_done),
    .cpu_rdata (cpu_rdata),
    .hit       (hit),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // CPU-side monitor: every cpu_done pulse must match the oldest queued response.
  initial begin : cpu_monitor
    cpu_exp_t e;
    forever begin
      @(negedge clk);
      if (cpu_done) begin
        if (cpu_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_cpu_done: got cpu_done=1, expected no response");
        end else begin
          e = cpu_q.pop_front();
          if (!e.we) check("cpu_rdata", {32'd0, cpu_rdata}, {32'd0, e.rdata});
        end
      end
    end
  end

  // Memory model: checks each request against the queue, checks it stays stable, acks after ack_delay.
  initial begin : mem_model
    mem_exp_t    e;
    int          wait_cnt;
    logic        h_we;
    logic [31:0] h_addr, h_wdata;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    wait_cnt  = 0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req) begin
        if (wait_cnt == 0) begin
          h_we = mem_we; h_addr = mem_addr; h_wdata = mem_wdata;
          if (mem_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_mem_req: got mem_req=1 addr=%0h, expected none", mem_addr);
          end else begin
            e = mem_q.pop_front();
            check("mem_we", {63'd0, mem_we}, {63'd0, e.we});
            check("mem_addr", {32'd0, mem_addr}, {32'd0, e.addr});
            if (e.we) check("mem_wdata", {32'd0, mem_wdata}, {32'd0, e.wdata});
          end
        end else begin
          check("mem_stable", {mem_we, mem_addr, mem_wdata}, {h_we, h_addr, h_wdata});
        end
        wait_cnt++;
        if (wait_cnt > ack_delay) begin
          mem_ack = 1'b1;
          for (int i = 0; i < 16; i++) mem_rdata[i*32 +: 32] = fill_base + 32'(i);
          last_req_len = wait_cnt;
          wait_cnt = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Issues one CPU op, queues its expectations and measures latency from the accept edge.
  task automatic cpu_op(input string name, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_hit, input int exp_lat, input logic exp_mem,
                        input logic [31:0] exp_maddr, input int delay, input logic [31:0] base);
    int   lat;
    logic saw_hit;
    logic done;
    ack_delay = delay;
    fill_base = base;
    cpu_q.push_back('{we: we, rdata: exp_rdata});
    if (exp_mem) mem_q.push_back('{we: we, addr: exp_maddr, wdata: wdata});
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    #1 check({name, "_ready"}, {63'd0, cpu_ready}, 64'd1);
    @(posedge clk);
    #1 cpu_req = 1'b0;
    lat = 0; saw_hit = 1'b0; done = 1'b0;
    while (!done && lat < 200) begin
      @(negedge clk);
      if (hit) saw_hit = 1'b1;
      if (cpu_done) done = 1'b1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    check({name, "_done_seen"}, {63'd0, done}, 64'd1);
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_hit"}, {63'd0, saw_hit}, {63'd0, exp_hit});
  endtask

  initial begin : stimulus
    int cyc;
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; flush = 1'b0;
    cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {63'd0, cpu_ready}, 64'd0);
    check("reset_mem_req", {63'd0, mem_req}, 64'd0);
    check("reset_done", {63'd0, cpu_done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_ready", {63'd0, cpu_ready}, 64'd1);
    check("reset_hit_cnt", {32'd0, hit_cnt}, 64'd0);
    check("reset_miss_cnt", {32'd0, miss_cnt}, 64'd0);

    // Cold miss, hit in same line, then conflict eviction on index 0.
    cpu_op("cold_rd", 1'b0, 32'h1004, 32'h0, 32'hA000_0001, 1'b0, 3, 1'b1, 32'h1000, 0, 32'hA000_0000);
    check("miss_cnt_1", {32'd0, miss_cnt}, 64'd1);
    cpu_op("hit_rd", 1'b0, 32'h1038, 32'h0, 32'hA000_000E, 1'b1, 2, 1'b0, 32'h0, 0, 32'h0);
    check("hit_cnt_1", {32'd0, hit_cnt}, 64'd1);
    cpu_op("evict_rd", 1'b0, 32'h2004, 32'h0, 32'hB000_0001, 1'b0, 4, 1'b1, 32'h2000, 1, 32'hB000_0000);
    cpu_op("reread", 1'b0, 32'h1004, 32'h0, 32'hA000_0001, 1'b0, 3, 1'b1, 32'h1000, 0, 32'hA000_0000);
    check("miss_cnt_3", {32'd0, miss_cnt}, 64'd3);

    // Bring 0x2000 back so the store hits, then write-through with a 3-cycle ack wait.
    cpu_op("rd_2000", 1'b0, 32'h2000, 32'h0, 32'hB000_0000, 1'b0, 3, 1'b1, 32'h2000, 0, 32'hB000_0000);
    cpu_op("wr_hit", 1'b1, 32'h2008, 32'hDEAD_BEEF, 32'h0, 1'b1, 6, 1'b1, 32'h2008, 3, 32'h0);
    check("wr_req_len", 64'(last_req_len), 64'd4);
    check("rdata_hold", {32'd0, cpu_rdata}, 64'hB000_0000);
    check("hit_cnt_2", {32'd0, hit_cnt}, 64'd2);
    cpu_op("rd_after_wr", 1'b0, 32'h2008, 32'h0, 32'hDEAD_BEEF, 1'b1, 2, 1'b0, 32'h0, 0, 32'h0);

    // Write miss does not allocate.
    cpu_op("wr_miss", 1'b1, 32'h3000, 32'h1234_5678, 32'h0, 1'b0, 3, 1'b1, 32'h3000, 0, 32'h0);
    cpu_op("rd_3000", 1'b0, 32'h3000, 32'h0, 32'hC000_0000, 1'b0, 3, 1'b1, 32'h3000, 0, 32'hC000_0000);
    check("miss_cnt_6", {32'd0, miss_cnt}, 64'd6);

    // Flush beats a same-cycle request and invalidates the resident line.
    @(negedge clk);
    flush = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h3000;
    #1 check("flush_blocks_ready", {63'd0, cpu_ready}, 64'd0);
    @(posedge clk);
    #1 flush = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    check("flush_req_dropped", {63'd0, cpu_ready}, 64'd1);
    check("flush_keeps_hits", {32'd0, hit_cnt}, 64'd3);
    cpu_op("rd_after_flush", 1'b0, 32'h3000, 32'h0, 32'hD000_0000, 1'b0, 3, 1'b1, 32'h3000, 0, 32'hD000_0000);
    cpu_op("rd_2008_miss", 1'b0, 32'h2008, 32'h0, 32'hE000_0002, 1'b0, 3, 1'b1, 32'h2000, 0, 32'hE000_0000);
    check("miss_cnt_8", {32'd0, miss_cnt}, 64'd8);

    // Reset in the middle of a fill.
    ack_delay = 1000;
    mem_q.push_back('{we: 1'b0, addr: 32'h1000, wdata: 32'h0});
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1004;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    cyc = 0;
    while (!mem_req && cyc < 20) begin
      @(posedge clk);
      #1 cyc++;
    end
    check("midfill_mem_req_seen", {63'd0, mem_req}, 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midfill_mem_req_drop", {63'd0, mem_req}, 64'd0);
    check("midfill_ready_low", {63'd0, cpu_ready}, 64'd0);
    @(negedge clk);
    check("midfill_no_done", {63'd0, cpu_done}, 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst_hit_cnt_zero", {32'd0, hit_cnt}, 64'd0);
    check("rst_miss_cnt_zero", {32'd0, miss_cnt}, 64'd0);
    check("rst_rdata_zero", {32'd0, cpu_rdata}, 64'd0);
    cpu_op("rd_after_rst", 1'b0, 32'h1004, 32'h0, 32'hA000_0001, 1'b0, 3, 1'b1, 32'h1000, 0, 32'hA000_0000);
    check("miss_cnt_after_rst", {32'd0, miss_cnt}, 64'd1);
    check("hit_cnt_after_rst", {32'd0, hit_cnt}, 64'd0);

    repeat (5) @(negedge clk);
    check("cpu_q_drained", 64'(cpu_q.size()), 64'd0);
    check("mem_q_drained", 64'(mem_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
